chx_rr_sched: RTL and testbench

Eight-channel packet scheduler that sits between the eight per-channel input controllers and the shared output datapath. It arbitrates whole packets: strict QoS priority (high before low) with independent round-robin rotation inside each class, and a burst limit on high-priority packets so low-priority traffic is never starved. It pulls bytes from the granted channel with a per-byte acknowledge and drives one registered byte stream downstream.

---
 rtl/chx_rr_sched_if.sv | 28 ++
 rtl/chx_rr_sched.sv | 118 +++++++++++
 tb/tb_chx_rr_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chx_rr_sched_if.sv
// Bundle between the eight channel controllers, the packet scheduler and the downstream byte sink.
// Handshake: a channel byte is consumed in the cycle its rr_ack bit is high; out_ready high means the sink can take one out_vld byte next cycle.
interface chx_rr_sched_if;
  logic [7:0]  rr_req;
  logic [7:0]  chx_qos;
  logic [63:0] chx_data;
  logic [7:0]  chx_sop;
  logic [7:0]  chx_eop;
  logic [7:0]  rr_ack;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_sop;
  logic        out_eop;
  logic        out_qos;
  logic [2:0]  out_id;
  logic        sop_err;

  modport master (
    output rr_req, chx_qos, chx_data, chx_sop, chx_eop, out_ready,
    input  rr_ack, out_data, out_vld, out_sop, out_eop, out_qos, out_id, sop_err
  );

  modport slave (
    input  rr_req, chx_qos, chx_data, chx_sop, chx_eop, out_ready,
    output rr_ack, out_data, out_vld, out_sop, out_eop, out_qos, out_id, sop_err
  );
endinterface

// File: rtl/chx_rr_sched.sv
// Eight-channel whole-packet scheduler: strict QoS with per-class round robin and a high-burst cap,
// streaming the granted channel's bytes through one output register.
module chx_rr_sched #(
  parameter int unsigned HI_BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  chx_rr_sched_if.slave  bus,
  output logic           dbg_xfer
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [3:0] HB = 4'(HI_BURST_MAX);

  state_t     state_q, state_d;
  logic [2:0] grant_q;
  logic       grant_qos_q;
  logic [2:0] hi_ptr_q, lo_ptr_q;
  logic [3:0] hi_cnt_q;
  logic       first_q;

  logic [7:0] hi_req, lo_req, ack_vec;
  logic       pick_lo;
  logic [2:0] hi_win, lo_win, win;
  logic [7:0] g_data;
  logic       g_sop, g_eop;

  // First requester strictly after ptr, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign hi_req  = bus.rr_req & bus.chx_qos;
  assign lo_req  = bus.rr_req & ~bus.chx_qos;
  assign pick_lo = ((hi_cnt_q == HB) && (|lo_req)) || !(|hi_req);
  assign hi_win  = rr_pick(hi_req, hi_ptr_q);
  assign lo_win  = rr_pick(lo_req, lo_ptr_q);
  assign win     = pick_lo ? lo_win : hi_win;

  assign g_data  = bus.chx_data[{grant_q, 3'b000} +: 8];
  assign g_sop   = bus.chx_sop[grant_q];
  assign g_eop   = bus.chx_eop[grant_q];

  always_comb begin
    state_d = state_q;
    ack_vec = 8'h00;
    case (state_q)
      IDLE: if (|bus.rr_req) state_d = XFER;
      XFER: begin
        if (bus.out_ready) begin
          ack_vec = 8'h01 << grant_q;
          if (g_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rr_ack = ack_vec;
  assign dbg_xfer   = (state_q == XFER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 3'd0;
      grant_qos_q  <= 1'b0;
      hi_ptr_q     <= 3'd7;
      lo_ptr_q     <= 3'd7;
      hi_cnt_q     <= 4'd0;
      first_q      <= 1'b0;
      bus.out_vld  <= 1'b0;
      bus.out_data <= 8'h00;
      bus.out_sop  <= 1'b0;
      bus.out_eop  <= 1'b0;
      bus.out_qos  <= 1'b0;
      bus.out_id   <= 3'd0;
      bus.sop_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus.out_vld <= |ack_vec;
      if (state_q == IDLE && (|bus.rr_req)) begin
        grant_q     <= win;
        grant_qos_q <= !pick_lo;
        first_q     <= 1'b1;
        if (pick_lo) begin
          lo_ptr_q <= win;
          hi_cnt_q <= 4'd0;
        end else begin
          hi_ptr_q <= win;
          // Count high grants only while low traffic is actually waiting.
          if (!(|lo_req))          hi_cnt_q <= 4'd0;
          else if (hi_cnt_q != HB) hi_cnt_q <= hi_cnt_q + 4'd1;
        end
      end
      if (|ack_vec) begin
        bus.out_data <= g_data;
        bus.out_sop  <= g_sop;
        bus.out_eop  <= g_eop;
        bus.out_qos  <= grant_qos_q;
        bus.out_id   <= grant_q;
        first_q      <= 1'b0;
        if (first_q && !g_sop) bus.sop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chx_rr_sched.sv
// Bench for chx_rr_sched: packet-level channel sources, a cycle reference model of the scheduling
// rules, directed scenarios with literal expected byte streams, then a randomized soak.
module tb_chx_rr_sched;
  localparam int HB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic dbg_xfer;

  chx_rr_sched_if bus();

  chx_rr_sched #(.HI_BURST_MAX(HB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_xfer(dbg_xfer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // channel sources: one packet in flight per channel
  bit         act[8];
  int         plen[8];
  int         pidx[8];
  bit         pqos[8];
  bit         pbad[8];
  logic [7:0] pdat[8][8];
  bit         rf_en[8];
  bit         rf_qos[8];
  bit         rand_mode = 1'b0;
  int         rdy_q[$];

  // reference model of the scheduler
  bit         m_busy, m_gqos, m_first;
  int         m_gnt, m_hicnt;
  int         m_ptr[2];
  logic       m_vld, m_sop, m_eop, m_qos, m_err;
  logic [7:0] m_data;
  logic [2:0] m_id;

  logic [13:0] log_q[$];
  logic [13:0] exp_q[$];

  task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  function automatic logic [13:0] ent(int id, bit q, bit s, bit e, logic [7:0] d);
    return {3'(id), q, s, e, d};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gqos = 0; m_first = 0; m_gnt = 0; m_hicnt = 0;
    m_ptr[0] = 7; m_ptr[1] = 7;
    m_vld = 0; m_sop = 0; m_eop = 0; m_qos = 0; m_err = 0; m_data = 8'h00; m_id = 3'd0;
  endtask

  task automatic load_pkt(int ch, bit q, int len, bit bad, logic [7:0] base);
    act[ch] = 1; plen[ch] = len; pidx[ch] = 0; pqos[ch] = q; pbad[ch] = bad;
    for (int k = 0; k < len; k++) pdat[ch][k] = base + 8'(k);
  endtask

  task automatic drive();
    logic [7:0]  r, q, s, e;
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      if (!act[i] && rf_en[i]) load_pkt(i, rf_qos[i], 1, 0, 8'(8'h30 + i));
      if (rand_mode && !act[i] && $urandom_range(0, 3) == 0)
        load_pkt(i, 1'($urandom_range(0, 1)), $urandom_range(1, 5),
                 $urandom_range(0, 19) == 0, 8'($urandom));
      r[i] = act[i];
      if (act[i]) begin
        q[i] = pqos[i];
        d[i*8 +: 8] = pdat[i][pidx[i]];
        s[i] = (pidx[i] == 0) && !pbad[i];
        e[i] = (pidx[i] == plen[i] - 1);
      end else begin
        q[i] = 1'b0;
        d[i*8 +: 8] = 8'($urandom);
        s[i] = 1'($urandom);
        e[i] = 1'($urandom);
      end
    end
    bus.rr_req = r; bus.chx_qos = q; bus.chx_data = d; bus.chx_sop = s; bus.chx_eop = e;
    if (rdy_q.size() != 0) bus.out_ready = 1'(rdy_q.pop_front());
    else if (rand_mode)    bus.out_ready = ($urandom_range(0, 3) != 0);
    else                   bus.out_ready = 1'b1;
  endtask

  task automatic step_cycle();
    logic [7:0] exp_ack;
    bit has_hi, has_lo, found;
    int cls, c, g;
    @(negedge clk);
    chk("out_vld", bus.out_vld, m_vld);
    chk("out_data", bus.out_data, m_data);
    chk("out_sop", bus.out_sop, m_sop);
    chk("out_eop", bus.out_eop, m_eop);
    chk("out_qos", bus.out_qos, m_qos);
    chk("out_id", bus.out_id, m_id);
    chk("sop_err", bus.sop_err, m_err);
    if (bus.out_vld) log_q.push_back({bus.out_id, bus.out_qos, bus.out_sop, bus.out_eop, bus.out_data});
    drive();
    #1;
    exp_ack = (m_busy && bus.out_ready) ? 8'(1 << m_gnt) : 8'h00;
    chk("rr_ack", bus.rr_ack, exp_ack);
    chk("state", dbg_xfer, m_busy);
    if (!m_busy) begin
      m_vld = 0;
      if (bus.rr_req != 8'h00) begin
        has_hi = |(bus.rr_req & bus.chx_qos);
        has_lo = |(bus.rr_req & ~bus.chx_qos);
        cls = (((m_hicnt == HB) && has_lo) || !has_hi) ? 0 : 1;
        found = 0; g = 0;
        for (int k = 1; k <= 8; k++) begin
          c = (m_ptr[cls] + k) % 8;
          if (!found && bus.rr_req[c] && (int'(bus.chx_qos[c]) == cls)) begin
            g = c; found = 1;
          end
        end
        m_gnt = g; m_gqos = (cls == 1); m_ptr[cls] = g; m_first = 1; m_busy = 1;
        if (cls == 0 || !has_lo) m_hicnt = 0;
        else if (m_hicnt < HB)   m_hicnt++;
      end
    end else if (bus.out_ready) begin
      g = m_gnt;
      m_vld = 1; m_data = bus.chx_data[g*8 +: 8];
      m_sop = bus.chx_sop[g]; m_eop = bus.chx_eop[g];
      m_qos = m_gqos; m_id = 3'(g);
      if (m_first && !m_sop) m_err = 1;
      m_first = 0;
      pidx[g]++;
      if (pidx[g] == plen[g]) act[g] = 0;
      if (m_eop) m_busy = 0;
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic run_until(int n, int budget, string name);
    int cyc = 0;
    while (log_q.size() < n && cyc < budget) begin
      step_cycle();
      cyc++;
    end
    if (log_q.size() < n) chk({"timeout_", name}, log_q.size(), n);
  endtask

  task automatic check_log(string name);
    while (exp_q.size() != 0) begin
      if (log_q.size() == 0) chk(name, 32'hFFFF, exp_q.pop_front());
      else                   chk(name, log_q.pop_front(), exp_q.pop_front());
    end
    log_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_mode = 0;
    rdy_q.delete();
    for (int i = 0; i < 8; i++) begin
      act[i] = 0; rf_en[i] = 0; rf_qos[i] = 0;
    end
    drive();
    #1;
    chk("rst_rr_ack", bus.rr_ack, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sop", bus.out_sop, 0);
    chk("rst_out_eop", bus.out_eop, 0);
    chk("rst_out_qos", bus.out_qos, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_sop_err", bus.sop_err, 0);
    chk("rst_state", dbg_xfer, 0);
    model_reset();
    log_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // single 3-byte low packet on channel 0
    load_pkt(0, 0, 3, 0, 8'hA1);
    run_until(3, 20, "a");
    exp_q.push_back(ent(0, 0, 1, 0, 8'hA1));
    exp_q.push_back(ent(0, 0, 0, 0, 8'hA2));
    exp_q.push_back(ent(0, 0, 0, 1, 8'hA3));
    check_log("pkt_a");

    // all eight low channels, 1-byte packets: pointer wraps 7->0
    do_reset();
    for (int i = 0; i < 8; i++) rf_en[i] = 1;
    run_until(9, 60, "rr");
    for (int i = 0; i < 9; i++) exp_q.push_back(ent(i % 8, 0, 1, 1, 8'(8'h30 + (i % 8))));
    check_log("rr_order");

    // ch7 high vs ch0 low: burst cap lets ch0 through after four high grants
    do_reset();
    rf_en[7] = 1; rf_qos[7] = 1; rf_en[0] = 1; rf_qos[0] = 0;
    run_until(6, 60, "burst");
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(7, 1, 1, 1, 8'h37));
    exp_q.push_back(ent(0, 0, 1, 1, 8'h30));
    exp_q.push_back(ent(7, 1, 1, 1, 8'h37));
    check_log("burst");

    // out_ready gaps inside a 4-byte packet
    do_reset();
    load_pkt(1, 1, 4, 0, 8'hD0);
    rdy_q = '{1, 1, 0, 0, 1, 1, 1, 1};
    run_until(4, 30, "stall");
    exp_q.push_back(ent(1, 1, 1, 0, 8'hD0));
    exp_q.push_back(ent(1, 1, 0, 0, 8'hD1));
    exp_q.push_back(ent(1, 1, 0, 0, 8'hD2));
    exp_q.push_back(ent(1, 1, 0, 1, 8'hD3));
    check_log("stall");

    // missing sop on channel 2 sets a sticky error
    do_reset();
    load_pkt(2, 0, 2, 1, 8'hE0);
    run_until(2, 20, "sop1");
    load_pkt(2, 0, 1, 0, 8'hE8);
    run_until(3, 20, "sop2");
    exp_q.push_back(ent(2, 0, 0, 0, 8'hE0));
    exp_q.push_back(ent(2, 0, 0, 1, 8'hE1));
    exp_q.push_back(ent(2, 0, 1, 1, 8'hE8));
    check_log("sop_err_pkts");
    step_cycle();
    chk("sop_err_sticky", bus.sop_err, 1);

    // reset mid-packet, then pointers must be back at 7
    do_reset();
    load_pkt(3, 0, 5, 0, 8'hF0);
    for (int cyc = 0; cyc < 20 && pidx[3] < 1; cyc++) step_cycle();
    chk("mid_pkt_progress", pidx[3], 1);
    #2;
    do_reset();
    load_pkt(0, 0, 1, 0, 8'h50);
    load_pkt(4, 0, 1, 0, 8'h54);
    run_until(2, 20, "post_rst");
    exp_q.push_back(ent(0, 0, 1, 1, 8'h50));
    exp_q.push_back(ent(4, 0, 1, 1, 8'h54));
    check_log("post_rst");

    // randomized soak against the model
    do_reset();
    rand_mode = 1;
    repeat (3000) step_cycle();
    rand_mode = 0;
    log_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
